// File: rtl/rsa_modexp_unit.sv
// Modular exponentiation unit: left-to-right square-and-multiply over an interleaved shift-add modular multiplier.
// Optional build macro RSA_LZ_SKIP_EN adds a SCAN state that skips leading exponent zeros.
module rsa_modexp_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             en_rsa,
    input  logic             rst_rsa,
    input  logic [WIDTH-1:0] plain,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] result,
    output logic             eoc_rsa_unit,
    output logic [2:0]       state_dbg
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
`ifdef RSA_LZ_SKIP_EN
    localparam logic [2:0] SCAN = 3'd2;
`endif
    localparam logic [2:0] SQR  = 3'd3;
    localparam logic [2:0] MUL  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] e_q, e_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             eoc_q, eoc_d;

    logic             go;
    logic [WIDTH-1:0] mcand;
    logic             mbit;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_red;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sum_red;
    logic [WIDTH-1:0] acc_next;

    always_comb begin
        go = en_rsa & rst_rsa;

        // One multiplier bit per cycle; R is the multiplier, P or R the multiplicand.
        mcand    = (state_q == MUL) ? p_q : r_q;
        mbit     = r_q[bcnt_q];
        m_ext    = {1'b0, m_q};
        dbl      = {acc_q, 1'b0};
        dbl_red  = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
        sum      = dbl_red + {1'b0, mcand};
        sum_red  = (sum >= m_ext) ? (sum - m_ext) : sum;
        acc_next = mbit ? sum_red[WIDTH-1:0] : dbl_red[WIDTH-1:0];

        state_d  = state_q;
        p_d      = p_q;
        e_d      = e_q;
        m_d      = m_q;
        r_d      = r_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        result_d = result_q;

        if (!go) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = LOAD;
                LOAD: begin
                    p_d    = plain;
                    e_d    = exponent;
                    m_d    = modulus;
                    r_d    = WIDTH'(1);
                    acc_d  = '0;
                    idx_d  = IW'(WIDTH - 1);
                    bcnt_d = IW'(WIDTH - 1);
                    if (modulus < WIDTH'(2)) begin
                        r_d      = '0;
                        result_d = '0;
                        state_d  = DONE;
                    end else begin
`ifdef RSA_LZ_SKIP_EN
                        state_d = SCAN;
`else
                        state_d = SQR;
`endif
                    end
                end
`ifdef RSA_LZ_SKIP_EN
                SCAN: begin
                    // Squaring R=1 is a no-op, so leading zeros cost one cycle each.
                    if (e_q[idx_q]) begin
                        state_d = MUL;
                    end else if (idx_q == '0) begin
                        r_d      = WIDTH'(1);
                        result_d = WIDTH'(1);
                        state_d  = DONE;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
`endif
                SQR, MUL: begin
                    acc_d = acc_next;
                    if (bcnt_q != '0) begin
                        bcnt_d = bcnt_q - 1'b1;
                    end else begin
                        acc_d  = '0;
                        bcnt_d = IW'(WIDTH - 1);
                        r_d    = acc_next;
                        if ((state_q == SQR) && e_q[idx_q]) begin
                            state_d = MUL;
                        end else if (idx_q == '0) begin
                            result_d = acc_next;
                            state_d  = DONE;
                        end else begin
                            idx_d   = idx_q - 1'b1;
                            state_d = SQR;
                        end
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        eoc_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q  <= IDLE;
            p_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            r_q      <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            result_q <= '0;
            eoc_q    <= 1'b0;
        end else if (ena) begin
            state_q  <= state_d;
            p_q      <= p_d;
            e_q      <= e_d;
            m_q      <= m_d;
            r_q      <= r_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            result_q <= result_d;
            eoc_q    <= eoc_d;
        end
    end

    assign result       = result_q;
    assign eoc_rsa_unit = eoc_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Directed and random runs of rsa_modexp_unit checked against a behavioural model of
// result and eoc latency; covers abort, ena stall, mid-run reset and input changes after LOAD.
module tb_rsa_modexp_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstb;
    logic         ena;
    logic         en_rsa;
    logic         rst_rsa;
    logic [W-1:0] plain;
    logic [W-1:0] exponent;
    logic [W-1:0] modulus;
    logic [W-1:0] result;
    logic         eoc_rsa_unit;
    logic [2:0]   state_dbg;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    int           lat_q[$];

    rsa_modexp_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .ena          (ena),
        .en_rsa       (en_rsa),
        .rst_rsa      (rst_rsa),
        .plain        (plain),
        .exponent     (exponent),
        .modulus      (modulus),
        .result       (result),
        .eoc_rsa_unit (eoc_rsa_unit),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] model_exp(input int p, input int e, input int m);
        longint r;
        if (m < 2) return '0;
        r = 1;
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * p) % m;
        end
        return W'(r);
    endfunction

    function automatic int model_lat(input int e, input int m);
        int pop;
        int h;
        if (m < 2) return 1;
        pop = 0;
        h   = -1;
        for (int i = 0; i < W; i++) begin
            if (e[i]) begin
                pop++;
                h = i;
            end
        end
`ifdef RSA_LZ_SKIP_EN
        if (h < 0) return 1 + W;
        return 1 + (W - h) + W * (h + pop);
`else
        return 1 + W * (W + pop);
`endif
    endfunction

    task automatic start_run(input int p, input int e, input int m);
        @(negedge clk);
        plain    = W'(p);
        exponent = W'(e);
        modulus  = W'(m);
        en_rsa   = 1'b1;
        rst_rsa  = 1'b1;
        exp_q.push_back(model_exp(p, e, m));
        lat_q.push_back(model_lat(e, m));
    endtask

    // Counts edges after go rises: the first edge enters LOAD (cycle 0).
    task automatic finish_run(input int pause_at, input int pause_len, input bit scramble);
        int           cyc;
        bit           got;
        logic [W-1:0] er;
        int           el;
        cyc = -1;
        got = 1'b0;
        for (int k = 0; k < 2000 && !got; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == pause_at) ena = 1'b0;
            if (cyc == pause_at + pause_len) ena = 1'b1;
            if (scramble && cyc == 3) begin
                plain    = W'($urandom_range(0, 255));
                exponent = W'($urandom_range(0, 255));
                modulus  = W'($urandom_range(0, 255));
            end
            if (eoc_rsa_unit) got = 1'b1;
        end
        ena = 1'b1;
        check("eoc_seen", 32'(got), 32'd1);
        er = exp_q.pop_front();
        el = lat_q.pop_front();
        check("result", 32'(result), 32'(er));
        check("latency", 32'(cyc), 32'(el + pause_len));
        @(negedge clk);
        en_rsa = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("eoc_clear", 32'(eoc_rsa_unit), 32'd0);
        check("result_hold", 32'(result), 32'(er));
    endtask

    initial begin
        int m;
        int p;
        int e;

        rstb     = 1'b0;
        ena      = 1'b1;
        en_rsa   = 1'b0;
        rst_rsa  = 1'b0;
        plain    = '0;
        exponent = '0;
        modulus  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", 32'(result), 32'd0);
        check("rst_eoc", 32'(eoc_rsa_unit), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk);
        rstb = 1'b1;

        start_run(88, 7, 187);   finish_run(-1, 0, 1'b0);
        start_run(11, 23, 187);  finish_run(-1, 0, 1'b0);
        start_run(0, 5, 1);      finish_run(-1, 0, 1'b0);
        start_run(5, 0, 187);    finish_run(-1, 0, 1'b0);

        // Abort at cycle 30: partial R discarded, result keeps 1 from the E=0 run.
        @(negedge clk);
        plain    = W'(88);
        exponent = W'(7);
        modulus  = W'(187);
        en_rsa   = 1'b1;
        rst_rsa  = 1'b1;
        repeat (31) @(posedge clk);
        #1;
        rst_rsa = 1'b0;
        @(posedge clk);
        #1;
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_eoc", 32'(eoc_rsa_unit), 32'd0);
        check("abort_result", 32'(result), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("abort_eoc_hold", 32'(eoc_rsa_unit), 32'd0);
        check("abort_result_hold", 32'(result), 32'd1);
        en_rsa = 1'b0;

        start_run(88, 7, 187);   finish_run(-1, 0, 1'b0);
        start_run(11, 23, 187);  finish_run(20, 10, 1'b0);

        for (int i = 0; i < 4; i++) begin
            m = $urandom_range(2, 255);
            p = $urandom_range(0, m - 1);
            e = $urandom_range(0, 255);
            start_run(p, e, m);
            finish_run(-1, 0, 1'b1);
        end
        start_run(200, 255, 251); finish_run(-1, 0, 1'b0);

        // Reset in the middle of a run.
        @(negedge clk);
        plain    = W'(88);
        exponent = W'(7);
        modulus  = W'(187);
        en_rsa   = 1'b1;
        rst_rsa  = 1'b1;
        repeat (41) @(posedge clk);
        #1;
        rstb   = 1'b0;
        en_rsa = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_eoc", 32'(eoc_rsa_unit), 32'd0);
        check("midrst_state", 32'(state_dbg), 32'd0);
        rstb = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
